// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types and constants for the serial ripple subtractor
package sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit-counter width; at least one bit so the counter is never zero-width
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// rtl/full_subtractor_bit.sv - single-bit combinational full subtractor cell
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference and borrow-out of a - b - bin for one bit
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_ripple_subtractor.sv
// rtl/serial_ripple_subtractor.sv - bit-serial LSB-first ripple-borrow subtractor
module serial_ripple_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last_bit;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             a_msb;
  logic             b_msb;
  logic             cell_d;
  logic             cell_bout;

  // The one cell reused every SHIFT cycle on the current LSBs and running borrow
  full_subtractor_bit u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last_bit = (cnt == LAST_CNT);
  assign busy     = (state == SHIFT);
  assign done     = (state == DONE);

  // Next-state logic; start is honoured in IDLE and in DONE for back-to-back use
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand capture, serial shift and result publication on the final bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      br    <= bin;
      res   <= '0;
      cnt   <= '0;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (state == SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      br   <= cell_bout;
      res  <= {cell_d, res[WIDTH-1:1]};
      if (last_bit) begin
        // The last cell output is the MSB of the difference
        diff   <= {cell_d, res[WIDTH-1:1]};
        borrow <= cell_bout;
        ovf    <= (a_msb ^ b_msb) & (cell_d ^ a_msb);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// tb/tb_serial_ripple_subtractor.sv - self-checking bench for serial_ripple_subtractor
module tb_serial_ripple_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;

  int total;
  int bad;

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, returns {ovf, borrow, diff}
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                           input logic rbin);
    int u;
    int sa;
    int sb;
    int s;
    logic [W-1:0] d;
    u  = int'(ra) - int'(rb) - int'(rbin);
    d  = W'(u);
    sa = ra[W-1] ? int'(ra) - (1 << W) : int'(ra);
    sb = rb[W-1] ? int'(rb) - (1 << W) : int'(rb);
    s  = sa - sb - int'(rbin);
    return {(s < -(1 << (W-1))) || (s > (1 << (W-1)) - 1), u < 0, d};
  endfunction

  // Issue one operation and wait (bounded) for done; optionally scramble inputs while busy
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                        input logic scramble,
                        output logic [W+1:0] got, output int bcyc,
                        output logic timed_out, output logic held);
    logic [W-1:0] prev;
    int n;
    @(negedge clk);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    prev = diff;
    @(negedge clk);
    start = 1'b0;
    n = 0; bcyc = 0; held = 1'b1;
    while (!done && n < 20) begin
      if (busy) bcyc++;
      if (diff !== prev) held = 1'b0;
      if (scramble) begin
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom); start = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    timed_out = (n >= 20);
    got = {ovf, borrow, diff};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, diff, borrow, ovf} !== '0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b diff=%b borrow=%b ovf=%b, want all 0",
               busy, done, diff, borrow, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5] = '{4'b0110, 4'b0011, 4'b0111, 4'b0000, 4'b1001};
    logic [W-1:0] tv [5] = '{4'b0010, 4'b1001, 4'b1000, 4'b0000, 4'b0011};
    logic         tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [W+1:0] ex [5] = '{6'b00_0100, 6'b11_1010, 6'b11_1111, 6'b01_1111, 6'b10_0110};
    logic [W+1:0] got;
    int bc;
    logic to, held;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tv[i], tc[i], 1'b0, got, bc, to, held);
      total++;
      if (to || got !== ex[i]) begin
        bad++;
        $display("FAIL directed_%0d: got {ovf,borrow,diff}=%b timeout=%b, want %b",
                 i, got, to, ex[i]);
      end
      total++;
      if (bc != W) begin
        bad++;
        $display("FAIL directed_busy_%0d: busy cycles %0d, want %0d", i, bc, W);
      end
    end
  endtask

  task automatic test_ignore_and_back_to_back();
    int n;
    @(negedge clk);
    a = 4'b1001; b = 4'b0011; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'b1111; b = 4'b0101; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    total++;
    if (n >= 20 || {ovf, borrow, diff} !== 6'b10_0110) begin
      bad++;
      $display("FAIL ignore_start: got %b timeout=%b, want 100110", {ovf, borrow, diff}, n >= 20);
    end
    a = 4'b0101; b = 4'b0001; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL back_to_back_gap: busy=%b after start in DONE, want 1", busy);
    end
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    total++;
    if (n >= 20 || {ovf, borrow, diff} !== ref_sub(4'b0101, 4'b0001, 1'b0)) begin
      bad++;
      $display("FAIL back_to_back_result: got %b, want %b", {ovf, borrow, diff},
               ref_sub(4'b0101, 4'b0001, 1'b0));
    end
  endtask

  task automatic test_mid_reset();
    logic [W+1:0] got;
    int bc;
    int seen_done;
    logic to, held;
    @(negedge clk);
    a = 4'b0011; b = 4'b1001; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, diff, borrow, ovf} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got busy=%b done=%b diff=%b borrow=%b ovf=%b, want 0",
               busy, done, diff, borrow, ovf);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    total++;
    if (seen_done != 0) begin
      bad++;
      $display("FAIL mid_reset_idle: busy/done seen %0d cycles after reset, want 0", seen_done);
    end
    run_op(4'b0111, 4'b1000, 1'b0, 1'b0, got, bc, to, held);
    total++;
    if (to || got !== ref_sub(4'b0111, 4'b1000, 1'b0)) begin
      bad++;
      $display("FAIL after_reset_op: got %b, want %b", got, ref_sub(4'b0111, 4'b1000, 1'b0));
    end
  endtask

  task automatic test_sweep();
    logic [W+1:0] got;
    logic [W+1:0] ex;
    int bc;
    logic to, held;
    for (int ci = 0; ci < 2; ci++)
      for (int ai = 0; ai < 16; ai++)
        for (int bi = 0; bi < 16; bi++) begin
          run_op(W'(ai), W'(bi), 1'(ci), 1'b0, got, bc, to, held);
          ex = ref_sub(W'(ai), W'(bi), 1'(ci));
          total++;
          if (to || got !== ex || bc != W) begin
            bad++;
            $display("FAIL sweep a=%0d b=%0d bin=%0d: got %b busy=%0d to=%b, want %b busy=%0d",
                     ai, bi, ci, got, bc, to, ex, W);
          end
          total++;
          if (!held) begin
            bad++;
            $display("FAIL sweep_hold a=%0d b=%0d bin=%0d: diff changed while busy, want stable",
                     ai, bi, ci);
          end
        end
  endtask

  task automatic test_random();
    logic [W+1:0] got;
    logic [W+1:0] ex;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    int bc;
    logic to, held;
    for (int i = 0; i < 60; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      run_op(ra, rb, rc, 1'b1, got, bc, to, held);
      ex = ref_sub(ra, rb, rc);
      total++;
      if (to || got !== ex || !held) begin
        bad++;
        $display("FAIL random a=%b b=%b bin=%b: got %b held=%b to=%b, want %b",
                 ra, rb, rc, got, held, to, ex);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_ignore_and_back_to_back();
    test_mid_reset();
    test_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
